avg_round_stage: RTL and testbench
==================================

AVG_ROUND_STAGE -- requirements
Module: avg_round_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 64: vector datapath width in bits; a multiple of 64.
REQ-002 Parameter DW_B, default DATA_WIDTH>>3: byte-lane count and width of the round-bit vectors.
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: the upstream shifted-average result is present.
REQ-006 Port in_ready, output, 1: the stage can accept a beat this cycle.
REQ-007 Port vec_in, input, DATA_WIDTH: per-element sum already shifted right by one.
REQ-008 Port v_d, input, DW_B: per-element bit d of the unshifted sum, which is the result LSB.
REQ-009 Port v_d1, input, DW_B: per-element bit d-1 of the unshifted sum, which is the bit shifted out.
REQ-010 Port sew, input, 2: element width; 0=8b, 1=16b, 2=32b, 3=64b.
REQ-011 Port vxrm, input, 2: rounding mode; 0=rnu, 1=rne, 2=rdn, 3=rod.
REQ-012 Port out_valid, output, 1: vec_out holds a valid rounded beat.
REQ-013 Port out_ready, input, 1: the downstream stage consumes the beat this cycle.
REQ-014 Port vec_out, output, DATA_WIDTH: rounded averaged vector.

Function
REQ-015 Element j at sew=s SHALL occupy vec_in bits [j*(8<<s) +: (8<<s)] and SHALL use v_d[j<<s] and v_d1[j<<s]; all other v_d/v_d1 bits are ignored.
REQ-016 The round increment r per element SHALL be:
- rnu: r=v_d1
- rne: r=v_d1&v_d
- rdn: r=0
- rod: r=v_d1&~v_d
REQ-017 Each element result SHALL be (element+r) modulo 2^(8<<s), with no carry crossing element boundaries.
REQ-018 A beat SHALL be accepted when in_valid && in_ready; vec_in, v_d, v_d1, sew and vxrm are sampled only on accept.
REQ-019 Rounding SHALL be computed combinationally on accept and stored in a 2-entry FIFO; a beat accepted in cycle N is visible on vec_out with out_valid=1 in cycle N+1 at the earliest.
REQ-020 in_ready SHALL equal (count<2), where count is a registered value, so in_ready has no combinational path from out_ready.
REQ-021 out_valid SHALL equal (count>0); vec_out SHALL be the head entry and SHALL hold stable while out_valid && !out_ready.
REQ-022 A pop occurs when out_valid && out_ready.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve beat order.
REQ-024 A push with count==2 cannot occur because in_ready=0 at that count.
REQ-025 A pop with count==0 SHALL be ignored.
REQ-026 FIFO read and write pointers are 1 bit each and SHALL wrap from 1 to 0.
REQ-027 Throughput SHALL be one beat per cycle while out_ready=1.

Reset
REQ-028 While rst=1: count=0, both pointers=0, out_valid=0, in_ready=0, vec_out=0.
REQ-029 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all buffered beats immediately and asynchronously, with no partial output.

Configuration
REQ-031 Macro AVG_ROUND_64B_EN: when defined, sew=3 SHALL be supported per REQ-015 to REQ-017.
REQ-032 When AVG_ROUND_64B_EN is undefined, a beat accepted with sew=3 SHALL still be accepted and produce vec_out=0; no 64-bit adder SHALL be synthesized.

Verification
REQ-033 Mode check: sew=0, byte0=0x3F, v_d[0]=1, v_d1[0]=1, issued in turn with vxrm=0,1,2,3 -> byte0 = 0x40, 0x40, 0x3F, 0x3F respectively.
REQ-034 Mode check: sew=0, byte0=0x3E, v_d[0]=0, v_d1[0]=1, issued in turn with vxrm=0,1,2,3 -> byte0 = 0x3F, 0x3E, 0x3E, 0x3F respectively.
REQ-035 Carry isolation: sew=0, vec_in=0x00FF, v_d1=0x01, vxrm=0 -> vec_out=0x0000, byte1 unchanged.
REQ-036 Wide element: sew=1, vec_in=0x00FF, v_d1[0]=1, vxrm=0 -> 0x0100; v_d1[1]=1 alone is ignored and gives 0x00FF.
REQ-037 Backpressure: out_ready=0, push beats A,B -> in_ready=0 after two accepts; raise out_ready -> A then B on consecutive cycles, and in_ready returns to 1.
REQ-038 Reset mid-flight: two beats buffered, assert rst -> out_valid=0 immediately; after deassert, no stale beat is emitted.

Source files
------------

// File: rtl/avg_round_stage_if.sv
// Stream bundle for the averaging round stage: upstream beat with rounding side bits, downstream rounded beat.
interface avg_round_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DW_B       = DATA_WIDTH >> 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] vec_in;
  logic [DW_B-1:0]       v_d;
  logic [DW_B-1:0]       v_d1;
  logic [1:0]            sew;
  logic [1:0]            vxrm;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] vec_out;

  modport slave (
    input  in_valid, vec_in, v_d, v_d1, sew, vxrm, out_ready,
    output in_ready, out_valid, vec_out
  );

  modport master (
    output in_valid, vec_in, v_d, v_d1, sew, vxrm, out_ready,
    input  in_ready, out_valid, vec_out
  );
endinterface

// File: rtl/avg_round_stage.sv
// Per-element rounding of a pre-shifted average, buffered in a 2-entry FIFO.
// Macro AVG_ROUND_64B_EN enables sew=3 (64-bit elements); otherwise sew=3 beats yield zero.
module avg_round_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int DW_B       = DATA_WIDTH >> 3
) (
  input  logic               clk,
  input  logic               rst,
  avg_round_stage_if.slave   bus
);

  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            count_nxt;
  logic                  rdy_q;
  logic                  push;
  logic                  pop;

  function automatic logic rnd_inc(input logic [1:0] mode, input logic d, input logic d1);
    case (mode)
      2'd0:    return d1;
      2'd1:    return d1 & d;
      2'd2:    return 1'b0;
      default: return d1 & ~d;
    endcase
  endfunction

  // Each element indexes its round bits at its lowest byte lane.
  always_comb begin
    res = '0;
    case (bus.sew)
      2'd0:
        for (int j = 0; j < DW_B; j++)
          res[j*8 +: 8] = bus.vec_in[j*8 +: 8]
                        + {7'd0, rnd_inc(bus.vxrm, bus.v_d[j], bus.v_d1[j])};
      2'd1:
        for (int j = 0; j < DW_B/2; j++)
          res[j*16 +: 16] = bus.vec_in[j*16 +: 16]
                          + {15'd0, rnd_inc(bus.vxrm, bus.v_d[j*2], bus.v_d1[j*2])};
      2'd2:
        for (int j = 0; j < DW_B/4; j++)
          res[j*32 +: 32] = bus.vec_in[j*32 +: 32]
                          + {31'd0, rnd_inc(bus.vxrm, bus.v_d[j*4], bus.v_d1[j*4])};
      default: begin
`ifdef AVG_ROUND_64B_EN
        for (int j = 0; j < DW_B/8; j++)
          res[j*64 +: 64] = bus.vec_in[j*64 +: 64]
                          + {63'd0, rnd_inc(bus.vxrm, bus.v_d[j*8], bus.v_d1[j*8])};
`else
        res = '0;
`endif
      end
    endcase
  end

  assign push = bus.in_valid && rdy_q;
  assign pop  = bus.out_ready && (count != 2'd0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Ready is registered from the next count so it never depends on out_ready this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rdy_q  <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= res;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count_nxt;
      rdy_q <= (count_nxt != 2'd2);
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.vec_out   = mem[rd_ptr];

endmodule

// File: tb/tb_avg_round_stage.sv
// Directed self-checking bench for avg_round_stage: rounding modes, element widths, flow control, reset.
module tb_avg_round_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  avg_round_stage_if bus ();

  avg_round_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [63:0] v, input logic [7:0] d, input logic [7:0] d1,
                       input logic [1:0] s, input logic [1:0] m);
    bus.vec_in = v;
    bus.v_d    = d;
    bus.v_d1   = d1;
    bus.sew    = s;
    bus.vxrm   = m;
  endtask

  // Pushes one beat with out_ready=1 and returns what appears on the output the next cycle.
  task automatic xfer(input logic [63:0] v, input logic [7:0] d, input logic [7:0] d1,
                      input logic [1:0] s, input logic [1:0] m,
                      output logic [63:0] got, output bit ok);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    drive(v, d, d1, s, m);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    ok  = acc && (bus.out_valid === 1'b1);
    got = bus.vec_out;
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++;
    if (bus.vec_out !== 64'd0) $display("FAIL reset_vec_out got=%h exp=0", bus.vec_out); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_modes;
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    logic [63:0] got;
    bit ok;
    exp_a = '{8'h40, 8'h40, 8'h3F, 8'h3F};
    exp_b = '{8'h3F, 8'h3E, 8'h3E, 8'h3F};
    for (int m = 0; m < 4; m++) begin
      xfer(64'h3F, 8'h01, 8'h01, 2'd0, 2'(m), got, ok);
      n_checks++;
      if (!ok || got[7:0] !== exp_a[m])
        $display("FAIL mode_3F vxrm=%0d ok=%0d got=%h exp=%h", m, ok, got[7:0], exp_a[m]);
      else n_pass++;
    end
    for (int m = 0; m < 4; m++) begin
      xfer(64'h3E, 8'h00, 8'h01, 2'd0, 2'(m), got, ok);
      n_checks++;
      if (!ok || got[7:0] !== exp_b[m])
        $display("FAIL mode_3E vxrm=%0d ok=%0d got=%h exp=%h", m, ok, got[7:0], exp_b[m]);
      else n_pass++;
    end
  endtask

  task automatic test_widths;
    logic [63:0] got;
    logic [63:0] exp64;
    bit ok;
    xfer(64'h00FF, 8'h00, 8'h01, 2'd0, 2'd0, got, ok);
    n_checks++;
    if (!ok || got !== 64'h0) $display("FAIL carry_isolation ok=%0d got=%h exp=0", ok, got); else n_pass++;
    xfer(64'h00FF, 8'h00, 8'h01, 2'd1, 2'd0, got, ok);
    n_checks++;
    if (!ok || got !== 64'h0100) $display("FAIL sew16_round ok=%0d got=%h exp=0100", ok, got); else n_pass++;
    xfer(64'h00FF, 8'h00, 8'h02, 2'd1, 2'd0, got, ok);
    n_checks++;
    if (!ok || got !== 64'h00FF) $display("FAIL sew16_ignored_lane ok=%0d got=%h exp=00ff", ok, got); else n_pass++;
    xfer(64'h01020304050607FF, 8'h00, 8'hFF, 2'd0, 2'd3, got, ok);
    n_checks++;
    if (!ok || got !== 64'h0203040506070800)
      $display("FAIL sew8_all_rod ok=%0d got=%h exp=0203040506070800", ok, got);
    else n_pass++;
    xfer(64'h7FFFFFFFFFFFFFFF, 8'h10, 8'h11, 2'd2, 2'd1, got, ok);
    n_checks++;
    if (!ok || got !== 64'h80000000FFFFFFFF)
      $display("FAIL sew32_rne ok=%0d got=%h exp=80000000ffffffff", ok, got);
    else n_pass++;
`ifdef AVG_ROUND_64B_EN
    exp64 = 64'h0000000100000000;
`else
    exp64 = 64'h0;
`endif
    xfer(64'h00000000FFFFFFFF, 8'h00, 8'h01, 2'd3, 2'd0, got, ok);
    n_checks++;
    if (!ok || got !== exp64) $display("FAIL sew64 ok=%0d got=%h exp=%h", ok, got, exp64); else n_pass++;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(64'hA1, 8'h00, 8'h00, 2'd0, 2'd2);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(64'hB2, 8'h00, 8'h00, 2'd0, 2'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.vec_out !== 64'hA1)
      $display("FAIL bp_head v=%b got=%h exp=a1", bus.out_valid, bus.vec_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.vec_out !== 64'hA1 || bus.in_ready !== 1'b0)
      $display("FAIL bp_hold got=%h rdy=%b exp=a1/0", bus.vec_out, bus.in_ready);
    else n_pass++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.vec_out !== 64'hB2)
      $display("FAIL bp_second v=%b got=%h exp=b2", bus.out_valid, bus.vec_out);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [63:0] beats [3];
    beats = '{64'h11, 64'h22, 64'h33};
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(beats[0], 8'h00, 8'h00, 2'd0, 2'd2);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) drive(beats[i+1], 8'h00, 8'h00, 2'd0, 2'd2);
      else bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.vec_out !== beats[i] || bus.in_ready !== 1'b1)
        $display("FAIL b2b_beat%0d v=%b got=%h rdy=%b exp=%h", i, bus.out_valid, bus.vec_out,
                 bus.in_ready, beats[i]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(64'h55, 8'h00, 8'h00, 2'd0, 2'd2);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(64'h66, 8'h00, 8'h00, 2'd0, 2'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL mid_buffered got=%b exp=1", bus.out_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.vec_out !== 64'd0)
      $display("FAIL mid_async_clear v=%b rdy=%b got=%h exp=0/0/0", bus.out_valid, bus.in_ready,
               bus.vec_out);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL mid_stale%0d got=%b exp=0", i, bus.out_valid); else n_pass++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", bus.in_ready); else n_pass++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(64'd0, 8'h00, 8'h00, 2'd0, 2'd0);
    test_reset();
    test_modes();
    test_widths();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
